// File: rtl/filter_arb_pkg.sv
// Shared types and default configuration for the filter engine arbiter.
package filter_arb_pkg;

  localparam int unsigned NChDefault        = 2;
  localparam int unsigned IoBDefault        = 16;
  localparam int unsigned TimeoutCycDefault = 64;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWait    = 2'd2,
    StDeliver = 2'd3
  } state_e;

endpackage

// File: rtl/filter_arb_rr_arbiter.sv
// Round-robin picker: first requester at or after (last_grant + 1) mod N_CH wins.
module rr_arbiter
  import filter_arb_pkg::*;
#(
  parameter int unsigned N_CH  = NChDefault,
  parameter int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             grant_valid
);

  int unsigned idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = (32'(last_grant) + i) % N_CH;
      if (!grant_valid && req[idx[IDX_W-1:0]]) begin
        grant       = idx[IDX_W-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/filter_arb.sv
// Shares one filter engine among N_CH sample channels, one sample in flight at a time.
// Optional WAIT timeout is built only when FILTER_ARB_TIMEOUT_EN is defined.
module filter_arb
  import filter_arb_pkg::*;
#(
  parameter int unsigned N_CH        = NChDefault,
  parameter int unsigned IO_B        = IoBDefault,
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_CH*IO_B-1:0] req_data,
  input  logic [N_CH-1:0]      req_valid,
  output logic [N_CH-1:0]      req_ready,
  output logic [IO_B-1:0]      eng_data,
  output logic                 eng_valid,
  input  logic [IO_B-1:0]      eng_result,
  input  logic                 eng_result_valid,
  output logic [IO_B-1:0]      res_data,
  output logic [N_CH-1:0]      res_valid,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned IdxW = $clog2(N_CH);

  state_e                     state_q, state_d;
  logic [N_CH-1:0]            pending_q, pending_d;
  logic [N_CH-1:0][IO_B-1:0]  slot_q;
  logic [IdxW-1:0]            grant_q, grant_d;
  logic [IdxW-1:0]            last_grant_q, last_grant_d;
  logic [IO_B-1:0]            res_data_q, res_data_d;
  logic [IdxW-1:0]            arb_grant;
  logic                       arb_valid;
  logic [N_CH-1:0]            accept;
  logic [N_CH-1:0]            grant_oh;
  logic [N_CH-1:0]            issue_clr;
  logic                       timeout_hit;

  rr_arbiter #(
    .N_CH  (N_CH),
    .IDX_W (IdxW)
  ) u_rr_arbiter (
    .req         (pending_q),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  assign grant_oh  = N_CH'(1) << grant_q;
  assign accept    = req_valid & ~pending_q;
  assign issue_clr = (state_q == StIssue) ? grant_oh : '0;
  assign pending_d = (pending_q | accept) & ~issue_clr;

`ifdef FILTER_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  assign wait_cnt_d  = (state_q == StWait) ? wait_cnt_q + 1'b1 : '0;
  // A result arriving in the final WAIT cycle still wins over the timeout.
  assign timeout_hit = (state_q == StWait) && !eng_result_valid &&
                       (wait_cnt_q == CntW'(TIMEOUT_CYC - 1));
  assign timeout_err = timeout_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_timeout_cyc;

  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    res_data_d   = res_data_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (eng_result_valid) begin
          res_data_d = eng_result;
          state_d    = StDeliver;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end
      end
      StDeliver: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      grant_q      <= '0;
      last_grant_q <= IdxW'(N_CH - 1);
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      res_data_q   <= res_data_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= '0;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (accept[k]) begin
          slot_q[k] <= req_data[k*IO_B +: IO_B];
        end
      end
    end
  end

  assign req_ready = ~pending_q;
  assign eng_valid = (state_q == StIssue);
  assign eng_data  = eng_valid ? slot_q[grant_q] : '0;
  assign res_valid = (state_q == StDeliver) ? grant_oh : '0;
  assign res_data  = res_data_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_filter_arb.sv
// Directed-vector bench for filter_arb; expectations queued by stimulus, checked by a monitor.
module tb_filter_arb;

  localparam int SnapRst     = 0;
  localparam int SnapReady   = 1;
  localparam int SnapBusy    = 2;
  localparam int SnapResData = 3;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } eng_exp_t;

  typedef struct {
    logic [1:0]  oh;
    logic [15:0] data;
    int          cyc;
  } res_exp_t;

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] val;
  } snap_exp_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] req_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] eng_data;
  logic        eng_valid;
  logic [15:0] eng_result;
  logic        eng_result_valid;
  logic [15:0] res_data;
  logic [1:0]  res_valid;
  logic        busy;
  logic        timeout_err;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic done;

  eng_exp_t  eng_q[$];
  res_exp_t  res_q[$];
  snap_exp_t snap_q[$];
  int        to_q[$];

  filter_arb #(
    .N_CH        (2),
    .IO_B        (16),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_data         (req_data),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .eng_data         (eng_data),
    .eng_valid        (eng_valid),
    .eng_result       (eng_result),
    .eng_result_valid (eng_result_valid),
    .res_data         (res_data),
    .res_valid        (res_valid),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void exp_eng(input logic [15:0] d, input int c);
    eng_q.push_back('{data: d, cyc: c});
  endfunction

  function automatic void exp_res(input logic [1:0] oh, input logic [15:0] d, input int c);
    res_q.push_back('{oh: oh, data: d, cyc: c});
  endfunction

  function automatic void exp_snap(input int c, input int kind, input logic [63:0] v);
    snap_q.push_back('{cyc: c, kind: kind, val: v});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_result(input int c, input logic [15:0] v);
    wait_to(c);
    eng_result       = v;
    eng_result_valid = 1'b1;
    tick();
    eng_result_valid = 1'b0;
  endtask

  // Monitor: every check in the bench happens here.
  initial begin : monitor
    eng_exp_t  e;
    res_exp_t  r;
    snap_exp_t s;
    int        tc;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      if (eng_valid) begin
        if (eng_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL eng_unexpected at cycle %0d: got issue of %0h, required none", cyc,
                   eng_data);
        end else begin
          e = eng_q.pop_front();
          chk("eng_data", eng_data, e.data);
          chk("eng_cycle", cyc, e.cyc);
        end
      end else begin
        chk("eng_data_idle", eng_data, 0);
      end
      if (res_valid != 2'b00) begin
        if (res_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL res_unexpected at cycle %0d: got res_valid %0b data %0h, required none",
                   cyc, res_valid, res_data);
        end else begin
          r = res_q.pop_front();
          chk("res_valid", res_valid, r.oh);
          chk("res_data", res_data, r.data);
          chk("res_cycle", cyc, r.cyc);
        end
      end
      if (timeout_err) begin
        if (to_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL timeout_unexpected at cycle %0d: got pulse, required none", cyc);
        end else begin
          tc = to_q.pop_front();
          chk("timeout_cycle", cyc, tc);
        end
      end
      for (int i = snap_q.size() - 1; i >= 0; i--) begin
        if (snap_q[i].cyc == cyc) begin
          s = snap_q[i];
          snap_q.delete(i);
          case (s.kind)
            SnapRst: chk("reset_outputs",
                         {eng_valid, eng_data, res_data, res_valid, busy, timeout_err, req_ready},
                         {1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 2'b11});
            SnapReady:   chk("req_ready", req_ready, s.val);
            SnapBusy:    chk("busy", busy, s.val);
            SnapResData: chk("res_data_hold", res_data, s.val);
            default:     chk("snap_kind", s.kind, 0);
          endcase
        end
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: got cycle %0d without completion, required completion", cyc);
    end
    chk("eng_q_drained", eng_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    chk("snap_q_drained", snap_q.size(), 0);
    chk("to_q_drained", to_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : stim
    int          t;
    int          ch;
    logic [15:0] v;
    done             = 1'b0;
    reset_n          = 1'b1;
    req_data         = '0;
    req_valid        = '0;
    eng_result       = '0;
    eng_result_valid = 1'b0;
    #1 reset_n = 1'b0;
    tick();
    exp_snap(cyc, SnapRst, 0);
    tick();
    exp_snap(cyc, SnapRst, 0);
    reset_n = 1'b1;
    tick();

    // Single request, result 5 cycles after issue.
    t = cyc;
    req_data[15:0] = 16'h1234;
    req_valid      = 2'b01;
    exp_eng(16'h1234, t + 2);
    exp_res(2'b01, 16'h0ABC, t + 8);
    exp_snap(t + 1, SnapReady, 2'b10);
    exp_snap(t + 5, SnapBusy, 1);
    exp_snap(t + 10, SnapResData, 16'h0ABC);
    exp_snap(t + 10, SnapBusy, 0);
    tick();
    req_valid = 2'b00;
    pulse_result(t + 7, 16'h0ABC);
    wait_to(t + 12);

    // Contention straight after reset: ch0 first.
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    t = cyc;
    req_data  = {16'h2222, 16'h1111};
    req_valid = 2'b11;
    exp_eng(16'h1111, t + 2);
    exp_res(2'b01, 16'hAAAA, t + 5);
    exp_eng(16'h2222, t + 7);
    exp_res(2'b10, 16'hBBBB, t + 10);
    tick();
    req_valid = 2'b00;
    pulse_result(t + 4, 16'hAAAA);
    pulse_result(t + 9, 16'hBBBB);
    wait_to(t + 12);

    // Fairness: both channels kept pending for 10 rounds of 4 cycles.
    t = cyc;
    req_data  = {16'h3100, 16'h3000};
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      ch = i % 2;
      v  = 16'(32'h3000 | (ch << 8) | (i / 2));
      exp_eng(v, t + 2 + 4 * i);
      exp_res(2'(1 << ch), 16'(32'h5000 + i), t + 4 + 4 * i);
    end
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 10; i++) begin
      ch = i % 2;
      wait_to(t + 3 + 4 * i);
      eng_result       = 16'(32'h5000 + i);
      eng_result_valid = 1'b1;
      if (i < 8) begin
        req_data[ch*16 +: 16] = 16'(32'h3000 | (ch << 8) | (i / 2 + 1));
        req_valid             = 2'(1 << ch);
      end
      tick();
      eng_result_valid = 1'b0;
      req_valid        = 2'b00;
    end
    wait_to(t + 44);

    // Back-pressure: second ch0 sample while pending is dropped.
    t = cyc;
    req_data[15:0] = 16'h4444;
    req_valid      = 2'b01;
    exp_eng(16'h4444, t + 2);
    exp_res(2'b01, 16'h6666, t + 4);
    exp_snap(t + 1, SnapReady, 2'b10);
    tick();
    req_data[15:0] = 16'h5555;
    req_valid      = 2'b01;
    tick();
    req_valid = 2'b00;
    pulse_result(t + 3, 16'h6666);
    wait_to(t + 10);

`ifndef FILTER_ARB_TIMEOUT_EN
    // Long engine latency: WAIT holds, no timeout.
    t = cyc;
    req_data[31:16] = 16'h7777;
    req_valid       = 2'b10;
    exp_eng(16'h7777, t + 2);
    exp_res(2'b10, 16'h8888, t + 84);
    exp_snap(t + 73, SnapBusy, 1);
    tick();
    req_valid = 2'b00;
    pulse_result(t + 83, 16'h8888);
    wait_to(t + 87);
`else
    // Timeout after 8 WAIT cycles, then a stray result is ignored.
    t = cyc;
    req_data[31:16] = 16'h7777;
    req_valid       = 2'b10;
    exp_eng(16'h7777, t + 2);
    to_q.push_back(t + 10);
    exp_snap(t + 6, SnapBusy, 1);
    exp_snap(t + 11, SnapBusy, 0);
    tick();
    req_valid = 2'b00;
    pulse_result(t + 13, 16'hBEEF);
    wait_to(t + 18);
`endif

    // Reset in WAIT: outputs cleared, late result ignored, ch0 wins next.
    t = cyc;
    req_data[15:0] = 16'h9999;
    req_valid      = 2'b01;
    exp_eng(16'h9999, t + 2);
    tick();
    req_valid = 2'b00;
    wait_to(t + 4);
    reset_n = 1'b0;
    exp_snap(t + 4, SnapRst, 0);
    exp_snap(t + 5, SnapRst, 0);
    tick();
    tick();
    reset_n = 1'b1;
    pulse_result(t + 7, 16'hDEAD);
    wait_to(t + 9);
    t = cyc;
    req_data  = {16'h0202, 16'h0101};
    req_valid = 2'b11;
    exp_eng(16'h0101, t + 2);
    exp_res(2'b01, 16'h1010, t + 4);
    exp_eng(16'h0202, t + 6);
    exp_res(2'b10, 16'h2020, t + 8);
    tick();
    req_valid = 2'b00;
    pulse_result(t + 3, 16'h1010);
    pulse_result(t + 7, 16'h2020);
    wait_to(t + 11);
    done = 1'b1;
  end

endmodule

// File: doc/filter_arb.md
FILTER_ARB -- requirements
Module: filter_arb

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of requesting sample channels, 2..8.
REQ-002 SHALL have parameter IO_B, default 16: sample width, matching the shared filter engine.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64: maximum WAIT-state cycles; used only when FILTER_ARB_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_data, input, N_CH*IO_B: channel k sample at bits [k*IO_B +: IO_B].
REQ-007 SHALL have port req_valid, input, N_CH: per-channel sample strobe.
REQ-008 SHALL have port req_ready, output, N_CH: per-channel hold slot is empty.
REQ-009 SHALL have port eng_data, output, IO_B: sample to the engine.
REQ-010 SHALL have port eng_valid, output, 1: one-cycle issue strobe to the engine.
REQ-011 SHALL have port eng_result, input, IO_B: engine output.
REQ-012 SHALL have port eng_result_valid, input, 1: engine output strobe.
REQ-013 SHALL have port res_data, output, IO_B: routed result.
REQ-014 SHALL have port res_valid, output, N_CH: one-hot, one-cycle result strobe to the owning channel.
REQ-015 SHALL have port busy, output, 1: asserted whenever the state is not IDLE.
REQ-016 SHALL have port timeout_err, output, 1: one-cycle pulse on an engine timeout.

Function
REQ-017 SHALL hold one IO_B-bit slot and one pending bit per channel; req_ready[k] = !pending[k].
REQ-018 SHALL capture req_data for channel k and set pending[k] on a rising edge where req_valid[k] and req_ready[k] are both high; a req_valid while not ready SHALL be ignored (sample dropped).
REQ-019 SHALL implement states IDLE, ISSUE, WAIT and DELIVER.
REQ-020 IDLE: if any pending bit is set, SHALL grant round-robin starting at (last_grant+1) mod N_CH, latch the grant index, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-021 ISSUE: SHALL drive eng_valid=1 and eng_data=slot[grant] for exactly one cycle, clear pending[grant] at the end of that cycle, and go to WAIT.
REQ-022 WAIT: on eng_result_valid SHALL capture eng_result into res_data and go to DELIVER.
REQ-023 DELIVER: SHALL drive res_valid = one-hot(grant) for one cycle, update last_grant to grant, and return to IDLE.
REQ-024 Latency: a sample accepted at edge t with the block idle SHALL see eng_valid high in cycle t+2; eng_result_valid in cycle r SHALL give res_valid in cycle r+1.
REQ-025 SHALL never have more than one sample outstanding at the engine.
REQ-026 SHALL ignore eng_result_valid in any state other than WAIT.
REQ-027 SHALL allow a new accept on the granted channel from the cycle after ISSUE; accepts on other channels SHALL proceed in every state.
REQ-028 res_data SHALL hold its last value between strobes; eng_data SHALL be 0 whenever eng_valid is low.

Reset
REQ-029 On reset_n low, SHALL immediately clear all pending bits, slots, res_data and eng_data to 0, state to IDLE, and last_grant to N_CH-1 so channel 0 wins first.
REQ-030 While reset is asserted, every output SHALL be 0 except req_ready, which SHALL be all ones.
REQ-031 A reset during WAIT SHALL abandon the outstanding sample; a later eng_result_valid SHALL be ignored per REQ-026.

Configuration
REQ-032 With FILTER_ARB_TIMEOUT_EN defined, a WAIT cycle counter SHALL run; on reaching TIMEOUT_CYC without a result, the block SHALL pulse timeout_err for one cycle, drop the sample with no res_valid, and return to IDLE.
REQ-033 Without FILTER_ARB_TIMEOUT_EN, WAIT SHALL last indefinitely, no counter SHALL be built, and timeout_err SHALL be tied to 0.

Structure
REQ-034 Package filter_arb_pkg SHALL hold the state enum typedef and the default constants for N_CH, IO_B and TIMEOUT_CYC.
REQ-035 The round-robin grant logic SHALL be a sub-module rr_arbiter, with inputs for the request vector and last grant, and outputs for the grant index and a grant-valid flag.

Verification
REQ-036 Single request: ch0 sample 0x1234 with result 0x0ABC returned 5 cycles after eng_valid -> eng_valid in cycle t+2 with eng_data=0x1234, res_valid=01, res_data=0x0ABC one cycle after the result.
REQ-037 Contention: ch0=0x1111 and ch1=0x2222 in the same cycle after reset -> ch0 is issued first, then ch1, and res_valid is 01 then 10.
REQ-038 Fairness: both channels always pending for 10 rounds -> grants alternate strictly, 5 per channel.
REQ-039 Back-pressure: a second req_valid on ch0 while pending[0]=1 -> req_ready[0]=0, the sample is dropped, and only the first sample is issued.
REQ-040 Timeout (macro on, TIMEOUT_CYC=8): no eng_result_valid -> timeout_err pulses 8 cycles into WAIT, no res_valid, state returns to IDLE; a stray result afterwards is ignored.
REQ-041 Reset in WAIT: reset_n low for 2 cycles -> all outputs match REQ-030, the late result is ignored, and the next request is granted to ch0.
